truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that exhaustively drives all 2^N_IN input combinations into a combinational gate-level block (e.g. a 5-input function such as two_c) and waits a programmable settle time per vector. It captures the output into a truth-table register and compares it against an expected signature. It replaces free-running counter stimulus with a clocked, self-checking start/done engine usable in-circuit or from a bench.

Parameters:
N_IN, 5, number of DUT inputs; vector count = 2^N_IN
SETTLE_CYCLES, 1, extra wait cycles after a vector is applied before sampling (0 allowed)
EXPECT, 32'h0000_0000, expected truth table, bit i = expected y for input vector i (width 2^N_IN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  cancel sweep in progress
dut_y  input  1  output of combinational DUT
dut_in  output  N_IN  vector driven to DUT; MSB = first DUT input (a), LSB = last (e)
busy  output  1  high from the cycle after start until return to IDLE
done  output  1  one-cycle pulse on sweep completion
table_out  output  2^N_IN  captured truth table, bit i = dut_y sampled with dut_in = i
match  output  1  table_out == EXPECT; valid from done, held until next start
mismatch_count  output  N_IN+1  number of mismatching vectors (0..2^N_IN)
first_fail_idx  output  N_IN  lowest failing vector index; 0 when mismatch_count == 0

Behaviour:
- Clock is clk; reset is rst: asynchronous, active-high. The reset applies to every flop.
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, table_out=0, match=0, mismatch_count=0, first_fail_idx=0, settle counter=0.
- dut_in is the registered vector index idx; there is no combinational path from inputs to dut_in.
- The FSM has four states: IDLE, SETTLE, SAMPLE and FINISH.
- IDLE: if start && !abort, then idx<=0, cnt<=SETTLE_CYCLES, and table_out, mismatch_count, first_fail_idx and match are cleared. busy<=1, go to SETTLE.
- SETTLE: if cnt==0, go to SAMPLE; else cnt<=cnt-1.
- SAMPLE:
  - table_out[idx]<=dut_y.
  - If dut_y != EXPECT[idx]: mismatch_count++; first_fail_idx<=idx if this is the first failure.
  - If idx == 2^N_IN-1, go to FINISH; else idx<=idx+1, cnt<=SETTLE_CYCLES, go to SETTLE.
- FINISH: done=1 for this cycle only. match<=(mismatch_count==0); this uses the final updated count, so compute it combinationally alongside the last SAMPLE update. Then busy<=0, dut_in<=0, go to IDLE.
- Timing:
  - Each vector is held for SETTLE_CYCLES+2 cycles.
  - The sweep takes 2^N_IN*(SETTLE_CYCLES+2) cycles after the start edge; done follows one cycle later.
  - Default (N_IN=5, SETTLE_CYCLES=1): done is high 97 cycles after the start edge.
- start while busy is ignored; there is no restart.
- abort in SETTLE, SAMPLE or FINISH:
  - Return to IDLE on the next edge with busy=0, dut_in=0, done=0.
  - table_out and the counters keep partial values; match stays 0.
- abort and start together in IDLE: abort wins and the block stays IDLE.
- abort in the same cycle as FINISH: done is suppressed.
- rst mid-sweep: everything returns to reset values immediately; no done.
- mismatch_count must not wrap: its width N_IN+1 holds 2^N_IN.

Decomposition:
- Shared package/header (vlsi_defs): state encodings (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, FINISH=2'd3) and default N_IN/SETTLE_CYCLES.
- One sub-module, sweep_settle_counter: loadable down-counter with zero flag, reused per vector.
- Comparison and table capture stay in the top module.

Test Plan:
- DUT stub y = XOR of 5 inputs, EXPECT=32'h9669_6996, pulse start: done at cycle 97 → table_out=32'h96696996, match=1, mismatch_count=0, dut_in steps 0..31 each held 3 cycles.
- Same stub, EXPECT=32'h9669_69B6 (bit 5 flipped) → mismatch_count=1, first_fail_idx=5, match=0.
- DUT stub y=1, EXPECT=0 → mismatch_count=32 (6'b100000, no wrap), first_fail_idx=0, match=0.
- SETTLE_CYCLES=0 instance → each vector held 2 cycles, done 65 cycles after start, table correct.
- abort asserted at cycle 20 → IDLE next edge, busy=0, dut_in=0, no done pulse; start at cycle 5 of a run ignored; start+abort in IDLE → stays IDLE.
- rst asserted asynchronously mid-SETTLE (between edges) → all outputs 0 immediately; a fresh start afterwards completes normally with match=1.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
// Holds the sequencer state encoding, default sizing parameters and a helper
// that sizes the per-vector settle counter.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StFinish = 2'd3
    } sweep_state_e;

    localparam int unsigned DefaultNIn          = 5;
    localparam int unsigned DefaultSettleCycles = 1;

    // Width needed to hold the settle reload value; never narrower than 1 bit.
    function automatic int unsigned settle_cnt_width(input int unsigned settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/sweep_settle_counter.sv
// Loadable down-counter with zero flag, reloaded once per swept vector.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset (count returns to 0)
//   load_i     - load load_val_i this cycle (has priority over dec_i)
//   load_val_i - reload value
//   dec_i      - decrement by one; ignored when already zero
//   zero_o     - count is zero
module sweep_settle_counter #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for a small combinational block.
// Steps dut_in through all 2^N_IN vectors, waits SETTLE_CYCLES extra cycles
// per vector, samples dut_y into table_out and compares against EXPECT.
// Ports:
//   clk, rst       - clock (rising edge) and asynchronous active-high reset
//   start          - begin a sweep (only honoured in idle)
//   abort          - cancel a sweep in progress; wins over start in idle
//   dut_y          - output of the block under test
//   dut_in         - registered vector index driven to the block (MSB = input a)
//   busy           - sweep in progress
//   done           - one-cycle pulse when a sweep completes
//   table_out      - captured truth table, bit i = dut_y with dut_in = i
//   match          - table_out == EXPECT, valid from done until next start
//   mismatch_count - number of failing vectors (0..2^N_IN)
//   first_fail_idx - lowest failing vector index, 0 if none
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned          N_IN          = DefaultNIn,
    parameter int unsigned          SETTLE_CYCLES = DefaultSettleCycles,
    parameter logic [2**N_IN-1:0]   EXPECT        = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                dut_y,
    output logic [N_IN-1:0]     dut_in,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  table_out,
    output logic                match,
    output logic [N_IN:0]       mismatch_count,
    output logic [N_IN-1:0]     first_fail_idx
);

    localparam int unsigned CntW = settle_cnt_width(SETTLE_CYCLES);

    sweep_state_e        state_q;
    logic [N_IN-1:0]     idx_q;
    logic                busy_q, done_q, match_q;
    logic [2**N_IN-1:0]  table_q;
    logic [N_IN:0]       mism_q;
    logic [N_IN-1:0]     first_fail_q;

    logic start_ok, idx_last, vec_fail, cnt_load, cnt_dec, cnt_zero;

    assign start_ok = (state_q == StIdle) && start && !abort;
    assign idx_last = &idx_q;
    assign vec_fail = (dut_y != EXPECT[idx_q]);

    // Reload on sweep start and on every vector advance; abort freezes the count.
    assign cnt_load = start_ok || ((state_q == StSample) && !abort && !idx_last);
    assign cnt_dec  = (state_q == StSettle) && !abort;

    sweep_settle_counter #(
        .Width (CntW)
    ) u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CntW'(SETTLE_CYCLES)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            table_q      <= '0;
            mism_q       <= '0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                // Partial table and counters are kept for inspection.
                state_q <= StIdle;
                busy_q  <= 1'b0;
                idx_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_ok) begin
                            idx_q        <= '0;
                            table_q      <= '0;
                            mism_q       <= '0;
                            first_fail_q <= '0;
                            match_q      <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= StSettle;
                        end
                    end
                    StSettle: begin
                        if (cnt_zero) begin
                            state_q <= StSample;
                        end
                    end
                    StSample: begin
                        table_q[idx_q] <= dut_y;
                        if (vec_fail) begin
                            mism_q <= mism_q + (N_IN+1)'(1);
                            if (mism_q == '0) begin
                                first_fail_q <= idx_q;
                            end
                        end
                        if (idx_last) begin
                            state_q <= StFinish;
                        end else begin
                            idx_q   <= idx_q + N_IN'(1);
                            state_q <= StSettle;
                        end
                    end
                    StFinish: begin
                        // mism_q already includes the last vector's result here.
                        done_q  <= 1'b1;
                        match_q <= (mism_q == '0);
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign dut_in         = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign table_out      = table_q;
    assign match          = match_q;
    assign mismatch_count = mism_q;
    assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: four instances share start/abort/rst.
//   g: XOR stub, correct EXPECT      b: XOR stub, EXPECT with bit 5 flipped
//   o: constant-1 stub, EXPECT = 0   f: XOR stub, SETTLE_CYCLES = 0
module tb_truth_table_sweeper;

    typedef struct {
        logic [31:0] tbl;
        logic        m;
        logic [5:0]  mc;
        logic [4:0]  ff;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic [4:0]  g_in, b_in, o_in, f_in;
    logic        g_busy, b_busy, o_busy, f_busy;
    logic        g_done, b_done, o_done, f_done;
    logic [31:0] g_tbl, b_tbl, o_tbl, f_tbl;
    logic        g_m, b_m, o_m, f_m;
    logic [5:0]  g_mc, b_mc, o_mc, f_mc;
    logic [4:0]  g_ff, b_ff, o_ff, f_ff;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(5), .SETTLE_CYCLES(1), .EXPECT(32'h9669_6996)) u_g (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(^g_in),
        .dut_in(g_in), .busy(g_busy), .done(g_done), .table_out(g_tbl), .match(g_m),
        .mismatch_count(g_mc), .first_fail_idx(g_ff)
    );
    truth_table_sweeper #(.N_IN(5), .SETTLE_CYCLES(1), .EXPECT(32'h9669_69B6)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(^b_in),
        .dut_in(b_in), .busy(b_busy), .done(b_done), .table_out(b_tbl), .match(b_m),
        .mismatch_count(b_mc), .first_fail_idx(b_ff)
    );
    truth_table_sweeper #(.N_IN(5), .SETTLE_CYCLES(1), .EXPECT(32'h0000_0000)) u_o (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(1'b1),
        .dut_in(o_in), .busy(o_busy), .done(o_done), .table_out(o_tbl), .match(o_m),
        .mismatch_count(o_mc), .first_fail_idx(o_ff)
    );
    truth_table_sweeper #(.N_IN(5), .SETTLE_CYCLES(0), .EXPECT(32'h9669_6996)) u_f (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(^f_in),
        .dut_in(f_in), .busy(f_busy), .done(f_done), .table_out(f_tbl), .match(f_m),
        .mismatch_count(f_mc), .first_fail_idx(f_ff)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results from a per-vector y table and the expected signature.
    function automatic exp_t model(input logic [31:0] ytab, input logic [31:0] sig);
        exp_t r;
        logic [31:0] diff;
        r.tbl = ytab;
        r.mc  = '0;
        r.ff  = '0;
        diff  = ytab ^ sig;
        for (int i = 31; i >= 0; i--) begin
            if (diff[i]) begin
                r.mc = r.mc + 6'd1;
                r.ff = 5'(i);
            end
        end
        r.m = (r.mc == 0);
        return r;
    endfunction

    function automatic logic [31:0] parity_table();
        logic [31:0] t;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            t[i] = ^v;
        end
        return t;
    endfunction

    task automatic push_all();
        sb_q.push_back(model(parity_table(), 32'h9669_6996));
        sb_q.push_back(model(parity_table(), 32'h9669_69B6));
        sb_q.push_back(model(32'hFFFF_FFFF, 32'h0000_0000));
        sb_q.push_back(model(parity_table(), 32'h9669_6996));
    endtask

    task automatic pop_check(input string tag, input logic [31:0] tbl, input logic m,
                             input logic [5:0] mc, input logic [4:0] ff);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_table"}, 64'(tbl), 64'(e.tbl));
            check({tag, "_match"}, 64'(m), 64'(e.m));
            check({tag, "_mcount"}, 64'(mc), 64'(e.mc));
            check({tag, "_ffidx"}, 64'(ff), 64'(e.ff));
        end
    endtask

    initial begin
        int waited;

        // Reset state
        #12;
        check("rst_busy", 64'(g_busy), 64'd0);
        check("rst_dut_in", 64'(g_in), 64'd0);
        check("rst_table", 64'(g_tbl), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_done", 64'(g_done), 64'd0);
        check("idle_match", 64'(g_m), 64'd0);
        check("idle_mcount", 64'(g_mc), 64'd0);
        check("idle_ffidx", 64'(g_ff), 64'd0);

        // Full sweep; start re-pulsed mid-run must be ignored
        start = 1'b1;
        push_all();
        tick();
        start = 1'b0;
        for (int e = 0; e <= 98; e++) begin
            if (e < 96) check($sformatf("g_dut_in_e%0d", e), 64'(g_in), 64'(e / 3));
            if (e < 64) check($sformatf("f_dut_in_e%0d", e), 64'(f_in), 64'(e / 2));
            check($sformatf("g_done_e%0d", e), 64'(g_done), 64'(e == 97));
            check($sformatf("f_done_e%0d", e), 64'(f_done), 64'(e == 65));
            check($sformatf("g_busy_e%0d", e), 64'(g_busy), 64'(e < 97));
            if (e == 97) begin
                check("b_done", 64'(b_done), 64'd1);
                check("o_done", 64'(o_done), 64'd1);
            end
            if (e == 5) start = 1'b1;
            if (e == 6) start = 1'b0;
            tick();
        end
        pop_check("g", g_tbl, g_m, g_mc, g_ff);
        pop_check("b", b_tbl, b_m, b_mc, b_ff);
        pop_check("o", o_tbl, o_m, o_mc, o_ff);
        pop_check("f", f_tbl, f_m, f_mc, f_ff);
        check("g_dut_in_after", 64'(g_in), 64'd0);

        // Abort sampled on edge 20 of a sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(g_busy), 64'd0);
        check("abort_dut_in", 64'(g_in), 64'd0);
        check("abort_done", 64'(g_done), 64'd0);
        check("abort_match", 64'(g_m), 64'd0);
        check("abort_partial_tbl", 64'(g_tbl), 64'h16);
        check("abort_b_mcount", 64'(b_mc), 64'd1);
        check("abort_b_ffidx", 64'(b_ff), 64'd5);
        waited = 0;
        for (int i = 0; i < 120; i++) begin
            if (g_done || g_busy) waited++;
            tick();
        end
        check("abort_no_done_later", 64'(waited), 64'd0);

        // start together with abort in idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(g_busy), 64'd0);
        tick();
        check("start_abort_dut_in", 64'(g_in), 64'd0);
        check("start_abort_done", 64'(g_done), 64'd0);

        // Asynchronous reset mid-SETTLE, then a clean sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(g_busy), 64'd0);
        check("arst_dut_in", 64'(g_in), 64'd0);
        check("arst_table", 64'(g_tbl), 64'd0);
        check("arst_b_mcount", 64'(b_mc), 64'd0);
        check("arst_b_ffidx", 64'(b_ff), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_no_done", 64'(g_done), 64'd0);

        start = 1'b1;
        push_all();
        tick();
        start = 1'b0;
        waited = 0;
        while (!g_done && waited < 200) begin
            tick();
            waited++;
        end
        check("rerun_done_seen", 64'(g_done), 64'd1);
        pop_check("g2", g_tbl, g_m, g_mc, g_ff);
        pop_check("b2", b_tbl, b_m, b_mc, b_ff);
        pop_check("o2", o_tbl, o_m, o_mc, o_ff);
        pop_check("f2", f_tbl, f_m, f_mc, f_ff);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
